// File: rtl/dense_pkg.sv
// Shared types and limits for the dense PE scheduler: FSM state encoding,
// tile/kernel bounds, default watchdog length and the configuration legality rule.
package dense_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam int MAX_TILE_W      = 32;
  localparam int MAX_K           = 3;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // A tile is legal when the kernel fits the PE rows and the image,
  // the stride is non-zero and the image fits the tile buffer.
  function automatic logic cfg_legal(input logic [2:0] k,
                                     input logic [5:0] img_w,
                                     input logic [2:0] stride,
                                     input int         max_k);
    return (k != 3'd0) && (int'(k) <= max_k) && (stride != 3'd0) &&
           (img_w >= {3'b000, k}) && (int'(img_w) <= MAX_TILE_W);
  endfunction

endpackage

// File: rtl/dense_pe_sched_wdog.sv
// WAIT-state watchdog for dense_pe_sched; exists only when
// DENSE_PE_SCHED_TIMEOUT_EN is defined.
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
module dense_pe_sched_wdog #(
  parameter int TIMEOUT_CYC = dense_pkg::TIMEOUT_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  logic [15:0] r_cnt;

  // Cleared while issuing so every entry to WAIT starts a fresh window.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= 16'd0;
    end else if (i_count && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expired = i_count && (r_cnt == 16'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/dense_pe_sched.sv
// Dense PE row scheduler: walks output rows (iy) and kernel rows (ky), issuing
// one PE pass per (iy, ky). Define DENSE_PE_SCHED_TIMEOUT_EN to add the WAIT watchdog.
module dense_pe_sched #(
  parameter int IA_ROW_MEM_ADDR     = 6,
  parameter int WEIGHT_ROW_MEM_ADDR = 7,
  parameter int MAX_K               = dense_pkg::MAX_K
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC         = dense_pkg::TIMEOUT_CYC_DEF
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2:0]                     K,
  input  logic [5:0]                     IMG_W,
  input  logic [7:0]                     OC,
  input  logic [2:0]                     STRIDE,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           pe_start,
  input  logic                           pe_done,
  output logic [MAX_K-1:0]               ia_row_mem_activate,
  output logic [MAX_K-1:0]               weight_row_mem_activate,
  output logic [IA_ROW_MEM_ADDR-1:0]     ia_row_sel,
  output logic [WEIGHT_ROW_MEM_ADDR-1:0] weight_row_sel,
  output logic                           timeout
);

  import dense_pkg::*;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_k;
  logic [5:0]  r_img_w;
  logic [2:0]  r_stride;
  logic [7:0]  r_oc;
  logic [7:0]  r_iy;
  logic [7:0]  r_ky;
  logic        r_err;
  logic        w_err_set;
  logic        w_ky_last;
  logic        w_more_rows;
  logic        w_active;
  logic [7:0]  w_iy_next;
  logic [7:0]  w_row_sum;
  logic [MAX_K-1:0] w_onehot;
  logic        w_unused_oc;

  // 8-bit sums: iy + STRIDE + K stays below 32 + 7 + 7, so nothing wraps.
  assign w_iy_next   = r_iy + {5'b00000, r_stride};
  assign w_ky_last   = (r_ky == ({5'b00000, r_k} - 8'd1));
  assign w_more_rows = ((w_iy_next + {5'b00000, r_k}) <= {2'b00, r_img_w});
  assign w_row_sum   = r_iy + r_ky;
  assign w_onehot    = MAX_K'(1) << r_ky;
  assign w_active    = (r_state == S_ISSUE) || (r_state == S_WAIT);

  // OC travels with the tile but the scheduler never looks at it.
  assign w_unused_oc = ^r_oc;

`ifdef DENSE_PE_SCHED_TIMEOUT_EN
  logic r_timeout;
  logic w_to_set;
  logic w_wdog_expired;

  dense_pe_sched_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clear  (r_state == S_ISSUE),
    .i_count  (r_state == S_WAIT),
    .o_expired(w_wdog_expired)
  );

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_err_set    = 1'b0;
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
    w_to_set     = 1'b0;
`endif
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_CHECK;
      S_CHECK: begin
        if (cfg_legal(r_k, r_img_w, r_stride, MAX_K)) begin
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
          w_err_set    = 1'b1;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (pe_done) begin
          w_next_state = S_NEXT;
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
        end else if (w_wdog_expired) begin
          w_next_state = S_IDLE;
          w_to_set     = 1'b1;
`endif
        end
      end
      S_NEXT: begin
        if (!w_ky_last || w_more_rows) w_next_state = S_ISSUE;
        else                           w_next_state = S_FIN;
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_k      <= 3'd0;
      r_img_w  <= 6'd0;
      r_stride <= 3'd0;
      r_oc     <= 8'd0;
      r_iy     <= 8'd0;
      r_ky     <= 8'd0;
      r_err    <= 1'b0;
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_err   <= w_err_set;
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
      r_timeout <= w_to_set;
`endif
      if ((r_state == S_IDLE) && start) begin
        r_k      <= K;
        r_img_w  <= IMG_W;
        r_stride <= STRIDE;
        r_oc     <= OC;
      end
      if (r_state == S_CHECK) begin
        r_iy <= 8'd0;
        r_ky <= 8'd0;
      end
      if (r_state == S_NEXT) begin
        if (!w_ky_last) begin
          r_ky <= r_ky + 8'd1;
        end else begin
          r_ky <= 8'd0;
          r_iy <= w_iy_next;
        end
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);
  assign err      = r_err;
  assign pe_start = (r_state == S_ISSUE);

  assign ia_row_mem_activate     = w_active ? w_onehot : '0;
  assign weight_row_mem_activate = w_active ? w_onehot : '0;
  assign ia_row_sel              = w_active ? IA_ROW_MEM_ADDR'(w_row_sum) : '0;
  assign weight_row_sel          = w_active ? WEIGHT_ROW_MEM_ADDR'(r_ky) : '0;

endmodule

// File: tb/tb_dense_pe_sched.sv
// Bench for dense_pe_sched: expected events from a loop-level reference model go
// into exp_q; a negedge monitor pops and compares. Honours DENSE_PE_SCHED_TIMEOUT_EN.
module tb_dense_pe_sched;

  localparam int W = 18;  // {kind[17:16], ia_sel[15:10], w_sel[9:3], act[2:0]}
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
  localparam int TCYC = 16;
`endif
  localparam logic [W-1:0] EV_DONE = {2'd1, 16'd0};
  localparam logic [W-1:0] EV_ERR  = {2'd2, 16'd0};
  localparam logic [W-1:0] EV_TO   = {2'd3, 16'd0};

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] K;
  logic [5:0] IMG_W;
  logic [7:0] OC;
  logic [2:0] STRIDE;
  logic       busy, done, err, pe_start, pe_done, timeout;
  logic [2:0] ia_row_mem_activate, weight_row_mem_activate;
  logic [5:0] ia_row_sel;
  logic [6:0] weight_row_sel;
  logic       resp_done  = 1'b0;
  logic       noise_done = 1'b0;

  assign pe_done = resp_done | noise_done;

  dense_pe_sched #(
    .IA_ROW_MEM_ADDR    (6),
    .WEIGHT_ROW_MEM_ADDR(7),
    .MAX_K              (3)
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT_CYC        (TCYC)
`endif
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .K                      (K),
    .IMG_W                  (IMG_W),
    .OC                     (OC),
    .STRIDE                 (STRIDE),
    .busy                   (busy),
    .done                   (done),
    .err                    (err),
    .pe_start               (pe_start),
    .pe_done                (pe_done),
    .ia_row_mem_activate    (ia_row_mem_activate),
    .weight_row_mem_activate(weight_row_mem_activate),
    .ia_row_sel             (ia_row_sel),
    .weight_row_sel         (weight_row_sel),
    .timeout                (timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_time_limit cyc=%0d required=finish", cyc);
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int start_seq = 0, start_cyc = 0, exp_tile_passes = 0, end_base = 0;  // driver-owned
  int seen_seq = 0, tile_passes = 0, end_count = 0, last_ps_cyc = 0;    // monitor-owned
  int resp_count = 0, last_resp_cyc = 0;                                // responder-owned
  int resp_limit = 1 << 30, dmin = 1, dmax = 1;                         // driver knobs

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic pop_check(input string name, input logic [W-1:0] got);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event got=%0h exp=none (cyc %0d)", name, got, cyc);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
      end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ev_pass(input int iy, input int ky);
    logic [2:0] act;
    act = (ky == 0) ? 3'b001 : (ky == 1) ? 3'b010 : 3'b100;
    return {2'd0, 6'(iy + ky), 7'(ky), act};
  endfunction

  function automatic bit legal(input int k, input int w, input int s);
    return (k >= 1) && (k <= 3) && (s >= 1) && (w >= k) && (w <= 32);
  endfunction

  // One pass per (output row, kernel row); stop early when limit passes were issued.
  task automatic model_tile(input int k, input int w, input int s, input int limit);
    int n = 0;
    if (!legal(k, w, s)) begin
      exp_q.push_back(EV_ERR);
      return;
    end
    for (int iy = 0; iy + k <= w; iy += s) begin
      for (int ky = 0; ky < k; ky++) begin
        if (n == limit) return;
        exp_q.push_back(ev_pass(iy, ky));
        n++;
      end
    end
    exp_q.push_back(EV_DONE);
  endtask

  // ---------------- PE array responder ----------------
  always begin
    int d;
    @(negedge clk);
    if (pe_start && !reset && (resp_count < resp_limit)) begin
      d = $urandom_range(dmax, dmin);
      resp_count++;
      repeat (d) @(posedge clk);
      #1;
      resp_done     = 1'b1;
      last_resp_cyc = cyc;
      @(posedge clk);
      #1;
      resp_done = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (pe_start) begin
        if (seen_seq != start_seq) begin
          seen_seq    = start_seq;
          tile_passes = 0;
          check("start_to_pe_start", cyc, start_cyc + 2);
        end else begin
          check("pe_done_to_pe_start", cyc, last_resp_cyc + 2);
        end
        tile_passes++;
        last_ps_cyc = cyc;
        pop_check("pass", {2'd0, ia_row_sel, weight_row_sel, ia_row_mem_activate});
        check("act_match", 32'(weight_row_mem_activate), 32'(ia_row_mem_activate));
      end
      if (done) begin
        pop_check("done", EV_DONE);
        check("pass_count", tile_passes, exp_tile_passes);
        end_count++;
      end
      if (err) begin
        pop_check("err", EV_ERR);
        check("err_latency", cyc, start_cyc + 2);
        check("busy_at_err", 32'(busy), 0);
        end_count++;
      end
      if (timeout) begin
        pop_check("timeout", EV_TO);
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
        check("timeout_latency", cyc, last_ps_cyc + TCYC + 1);
`endif
        end_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] out_vec();
    return {8'd0, busy, done, err, pe_start, timeout, ia_row_mem_activate,
            weight_row_mem_activate, ia_row_sel, weight_row_sel};
  endfunction

  task automatic launch(input int k, input int w, input int s, input int limit);
    model_tile(k, w, s, limit);
    exp_tile_passes = legal(k, w, s) ? k * ((w - k) / s + 1) : 0;
    end_base = end_count;
    @(posedge clk);
    #1;
    K = 3'(k); IMG_W = 6'(w); STRIDE = 3'(s); OC = 8'($urandom);
    start = 1'b1;
    start_cyc = cyc;
    start_seq++;
    @(posedge clk);
    #1;
    start = 1'b0;
    K = 3'($urandom); IMG_W = 6'($urandom); STRIDE = 3'($urandom);
  endtask

  // With noise set, start is pulsed (with junk config) in the WAIT cycle after each pe_start.
  task automatic wait_end(input int budget, input bit noise);
    int n = 0;
    while ((end_count == end_base) && (n < budget)) begin
      @(negedge clk);
      n++;
      if (noise && pe_start) begin
        @(posedge clk);
        #1;
        start = 1'b1; K = 3'($urandom_range(1, 3)); IMG_W = 6'($urandom_range(3, 20));
        STRIDE = 3'($urandom_range(1, 3));
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    check("tile_ended", 32'(end_count != end_base), 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run(input int k, input int w, input int s, input bit noise);
    launch(k, w, s, 1 << 30);
    wait_end(3000, noise);
  endtask

  task automatic wait_passes(input int n, input int budget);
    int c = 0;
    while (!((seen_seq == start_seq) && (tile_passes >= n)) && (c < budget)) begin
      @(negedge clk);
      c++;
    end
    check("reached_pass", 32'((seen_seq == start_seq) && (tile_passes >= n)), 1);
  endtask

  task automatic pulse_idle_done();
    @(posedge clk);
    #1;
    noise_done = 1'b1;
    @(posedge clk);
    #1;
    noise_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; K = 3'd0; IMG_W = 6'd0; OC = 8'd0; STRIDE = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 0);
    reset = 1'b0;

    // Dense walk, then strided walk, pe_done one cycle after pe_start.
    dmin = 1; dmax = 1;
    run(3, 5, 1, 1'b0);
    run(3, 8, 2, 1'b0);

    // Illegal configurations.
    run(0, 5, 1, 1'b0);
    run(3, 5, 0, 1'b0);
    run(3, 2, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("busy_after_errs", 32'(busy), 0);

    // pe_done while idle and start while waiting must not disturb the tile.
    dmin = 1; dmax = 3;
    pulse_idle_done();
    pulse_idle_done();
    run(2, 6, 1, 1'b1);
    pulse_idle_done();
    #1;
    check("idle_after_noise", 32'(busy), 0);

    // Reset while waiting on the 4th pass, then a minimal tile.
    dmin = 1; dmax = 1;
    resp_limit = resp_count + 3;
    launch(3, 5, 1, 4);
    wait_passes(4, 200);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("outputs_after_reset", out_vec(), 0);
    check("reset_queue", exp_q.size(), 0);
    reset = 1'b0;
    resp_limit = 1 << 30;
    run(1, 1, 1, 1'b0);

    // Withheld pe_done.
    resp_limit = resp_count;
    launch(3, 6, 1, 1);
`ifdef DENSE_PE_SCHED_TIMEOUT_EN
    exp_q.push_back(EV_TO);
    wait_end(200, 1'b0);
    @(posedge clk);
    #1;
    check("idle_after_timeout", 32'(busy), 0);
`else
    repeat (40) @(negedge clk);
    check("stall_busy", 32'(busy), 1);
    check("stall_no_timeout", 32'(timeout), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("stall_queue", exp_q.size(), 0);
`endif
    resp_limit = 1 << 30;

    // Randomised tiles, some illegal, variable PE latency, optional start noise.
    for (int t = 0; t < 14; t++) begin
      dmin = 1;
      dmax = $urandom_range(1, 4);
      run($urandom_range(0, 3), $urandom_range(0, 36), $urandom_range(0, 4),
          1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_pe_sched.md
DENSE_PE_SCHED -- requirements
Module: dense_pe_sched

Interface
REQ-001 The block SHALL have parameter IA_ROW_MEM_ADDR, default 6, meaning the input-activation row select width.
REQ-002 The block SHALL have parameter WEIGHT_ROW_MEM_ADDR, default 7, meaning the weight row select width.
REQ-003 The block SHALL have parameter MAX_K, default 3, meaning the maximum kernel size and the number of PE rows.
REQ-004 The block SHALL have these ports:
- clk  input  1: the single clock.
- reset  input  1: synchronous, active-high reset.
- start  input  1: one-cycle tile start request.
- K  input  3: kernel size.
- IMG_W  input  6: tile image width/height.
- OC  input  8: output channels; passed through and not interpreted.
- STRIDE  input  3: convolution stride.
- busy  output  1: high in any state except IDLE.
- done  output  1: one-cycle pulse on tile completion.
- err  output  1: one-cycle pulse on illegal configuration.
- pe_start  output  1: one-cycle start pulse to the PE array.
- pe_done  input  1: PE array pass complete.
- ia_row_mem_activate  output  MAX_K: one-hot PE-row enable.
- weight_row_mem_activate  output  MAX_K: same one-hot as ia_row_mem_activate.
- ia_row_sel  output  IA_ROW_MEM_ADDR: input row index iy+ky.
- weight_row_sel  output  WEIGHT_ROW_MEM_ADDR: kernel row ky.
- timeout  output  1: one-cycle watchdog pulse (macro-dependent).

Function
REQ-005 The state machine SHALL have states IDLE, CHECK, ISSUE, WAIT, NEXT, FIN.
REQ-006 IDLE SHALL go to CHECK when start=1, and SHALL latch K, IMG_W, STRIDE and OC in that cycle.
REQ-007 CHECK SHALL pulse err and return to IDLE if the latched K=0, K>MAX_K, STRIDE=0, IMG_W<K or IMG_W>32; otherwise it SHALL set iy=0, ky=0 and go to ISSUE.
REQ-008 ISSUE SHALL hold pe_start=1 for exactly one cycle and then go to WAIT.
REQ-009 From ISSUE through WAIT, ia_row_sel SHALL equal iy+ky, weight_row_sel SHALL equal ky, and both activate buses SHALL be (1<<ky).
REQ-010 pe_done SHALL be sampled only in WAIT; a pe_done asserted in ISSUE or in any other state SHALL be ignored.
REQ-011 WAIT SHALL go to NEXT on pe_done=1.
REQ-012 NEXT SHALL advance the loop as follows:
- if ky<K-1, ky++ and go to ISSUE;
- else ky=0 and iy+=STRIDE; if the new iy+K<=IMG_W, go to ISSUE, else go to FIN.
REQ-013 Loop arithmetic SHALL use at least 8-bit unsigned sums so that iy+STRIDE+K cannot wrap, and SHALL use no divider.
REQ-014 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-015 start SHALL be ignored in every state other than IDLE.
REQ-016 Minimum start-to-first-pe_start latency SHALL be 2 cycles: start seen in IDLE at cycle 0, CHECK at cycle 1, pe_start at cycle 2.
REQ-017 Each pass after a pe_done SHALL take 2 cycles to the next pe_start (NEXT, then ISSUE).
REQ-018 Total pe_start pulses per legal tile SHALL equal K*OH, where OH = floor((IMG_W-K)/STRIDE)+1.

Reset
REQ-019 reset=1 SHALL force state IDLE from any state, including mid-WAIT.
REQ-020 reset=1 SHALL clear all latched configuration and counters.
REQ-021 reset=1 SHALL drive every output to 0 on the next clock edge.
REQ-022 Reset SHALL take priority over start and pe_done in the same cycle.

Configuration
REQ-023 With DENSE_PE_SCHED_TIMEOUT_EN defined, a 16-bit watchdog SHALL count WAIT cycles.
REQ-024 With DENSE_PE_SCHED_TIMEOUT_EN defined, the watchdog SHALL pulse timeout and go to IDLE (no done) after parameter TIMEOUT_CYC (default 1024) cycles without pe_done.
REQ-025 With DENSE_PE_SCHED_TIMEOUT_EN defined, the watchdog SHALL clear on every entry to WAIT.
REQ-026 Without DENSE_PE_SCHED_TIMEOUT_EN, timeout SHALL be tied to 0, no watchdog logic SHALL exist, and WAIT SHALL be unbounded.

Structure
REQ-027 State encoding, MAX_TILE_W=32, MAX_K=3 and the default TIMEOUT_CYC SHALL live in shared package dense_pkg.
REQ-028 The watchdog SHALL be sub-module dense_pe_sched_wdog, instantiated only under DENSE_PE_SCHED_TIMEOUT_EN.

Verification
REQ-029 K=3, IMG_W=5, STRIDE=1, pe_done one cycle after every pe_start -> 9 pe_start pulses, ia_row_sel 0,1,2,1,2,3,2,3,4, weight_row_sel 0,1,2 repeating, then one done pulse.
REQ-030 K=3, IMG_W=8, STRIDE=2 -> iy=0,2,4 and 9 pulses with ia_row_sel 0,1,2,2,3,4,4,5,6, then done.
REQ-031 K=0, then separately STRIDE=0, then K=3 with IMG_W=2 -> err pulse 2 cycles after start, zero pe_start pulses, busy low afterwards.
REQ-032 reset asserted in WAIT at the 4th pass -> all outputs 0 next cycle; a following K=1, IMG_W=1, STRIDE=1 start -> exactly 1 pe_start, then done.
REQ-033 start pulsed during WAIT and pe_done pulsed in IDLE -> both ignored, pass count unchanged.
REQ-034 With DENSE_PE_SCHED_TIMEOUT_EN defined, TIMEOUT_CYC=16 and pe_done withheld -> timeout pulse after 16 WAIT cycles, IDLE, no done; without the macro, timeout stays 0.
